// File: rtl/sram_arbiter_if.sv
// Bus bundle for the two-master SRAM arbiter. It holds the CPU and DMA
// request/response channels, the SRAM pin group and the status outputs.
// "master" is the system side (both requesters plus the SRAM device).
// "slave" is the arbiter itself.
interface sram_arbiter_if #(
  parameter int ADDR_W = 20,
  parameter int DATA_W = 16
);
  // CPU requester channel
  logic              CPU_Req;
  logic              CPU_WE;
  logic [ADDR_W-1:0] CPU_Addr;
  logic [DATA_W-1:0] CPU_Wdata;
  logic [DATA_W-1:0] CPU_Rdata;
  logic              CPU_Ack;

  // Secondary (loader / debug) requester channel
  logic              DMA_Req;
  logic              DMA_WE;
  logic [ADDR_W-1:0] DMA_Addr;
  logic [DATA_W-1:0] DMA_Wdata;
  logic [DATA_W-1:0] DMA_Rdata;
  logic              DMA_Ack;

  // SRAM pins
  logic [ADDR_W-1:0] SRAM_ADDR;
  logic [DATA_W-1:0] SRAM_Dout;
  logic              SRAM_Doe;
  logic [DATA_W-1:0] SRAM_Din;
  logic              SRAM_CE_N;
  logic              SRAM_OE_N;
  logic              SRAM_WE_N;

  // Status
  logic              Busy;
  logic              Owner;

  modport master (
    output CPU_Req, CPU_WE, CPU_Addr, CPU_Wdata,
    input  CPU_Rdata, CPU_Ack,
    output DMA_Req, DMA_WE, DMA_Addr, DMA_Wdata,
    input  DMA_Rdata, DMA_Ack,
    input  SRAM_ADDR, SRAM_Dout, SRAM_Doe, SRAM_CE_N, SRAM_OE_N, SRAM_WE_N,
    output SRAM_Din,
    input  Busy, Owner
  );

  modport slave (
    input  CPU_Req, CPU_WE, CPU_Addr, CPU_Wdata,
    output CPU_Rdata, CPU_Ack,
    input  DMA_Req, DMA_WE, DMA_Addr, DMA_Wdata,
    output DMA_Rdata, DMA_Ack,
    output SRAM_ADDR, SRAM_Dout, SRAM_Doe, SRAM_CE_N, SRAM_OE_N, SRAM_WE_N,
    input  SRAM_Din,
    output Busy, Owner
  );
endinterface

// File: rtl/sram_arbiter.sv
// Round-robin arbiter and access sequencer for a single-ported SRAM.
// It is shared by the LC-3 CPU (port 0) and a secondary master (port 1).
// Each access runs IDLE -> ACCESS (wait states) -> ACK -> IDLE.
// Every SRAM pin and every response is registered.
module sram_arbiter #(
  parameter int ADDR_W  = 20,
  parameter int DATA_W  = 16,
  parameter int RD_WAIT = 2,
  parameter int WR_WAIT = 2
) (
  input  logic          Clk,
  input  logic          Reset_n,
  sram_arbiter_if.slave bus
);

  localparam int MAX_WAIT = (RD_WAIT > WR_WAIT) ? RD_WAIT : WR_WAIT;
  localparam int CNT_W    = $clog2(MAX_WAIT) + 1;
  localparam logic [CNT_W-1:0] RD_LOAD = CNT_W'(RD_WAIT - 1);
  localparam logic [CNT_W-1:0] WR_LOAD = CNT_W'(WR_WAIT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    ACK    = 2'd2
  } state_t;

  state_t            state_reg;
  logic              owner_reg;
  logic [CNT_W-1:0]  cnt_reg;
  logic              we_reg;
  logic [ADDR_W-1:0] addr_reg;
  logic [DATA_W-1:0] dout_reg;
  logic              doe_reg;
  logic              ce_n_reg;
  logic              oe_n_reg;
  logic              we_n_reg;
  logic              busy_reg;

  // Port-indexed views of the two requesters: index 0 = CPU, 1 = DMA
  logic [1:0]        req_vec;
  logic [1:0]        we_vec;
  logic [ADDR_W-1:0] addr_vec  [2];
  logic [DATA_W-1:0] wdata_vec [2];
  logic [DATA_W-1:0] rdata_reg [2];
  logic              ack_reg   [2];

  logic              grant_valid;
  logic              grant_port;
  logic              access_done;

  assign req_vec      = {bus.DMA_Req, bus.CPU_Req};
  assign we_vec       = {bus.DMA_WE,  bus.CPU_WE};
  assign addr_vec[0]  = bus.CPU_Addr;
  assign addr_vec[1]  = bus.DMA_Addr;
  assign wdata_vec[0] = bus.CPU_Wdata;
  assign wdata_vec[1] = bus.DMA_Wdata;

  // Single requester wins outright. On a tie, the port that did not own the
  // last access wins. Owner resets to DMA, so the CPU takes the first tie.
  assign grant_valid = |req_vec;
  assign grant_port  = req_vec[1] & (~req_vec[0] | ~owner_reg);

  // Last wait-state cycle: the strobe ends on this edge and read data is sampled.
  assign access_done = (state_reg == ACCESS) && (cnt_reg == '0);

  // Sequencer: the grant latches the request, then the strobes and status
  // registers are driven for each phase.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_reg <= IDLE;
      owner_reg <= 1'b1;
      cnt_reg   <= '0;
      we_reg    <= 1'b0;
      addr_reg  <= '0;
      dout_reg  <= '0;
      doe_reg   <= 1'b0;
      ce_n_reg  <= 1'b1;
      oe_n_reg  <= 1'b1;
      we_n_reg  <= 1'b1;
      busy_reg  <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (grant_valid) begin
            state_reg <= ACCESS;
            owner_reg <= grant_port;
            we_reg    <= we_vec[grant_port];
            addr_reg  <= addr_vec[grant_port];
            ce_n_reg  <= 1'b0;
            busy_reg  <= 1'b1;
            if (we_vec[grant_port]) begin
              cnt_reg  <= WR_LOAD;
              we_n_reg <= 1'b0;
              doe_reg  <= 1'b1;
              dout_reg <= wdata_vec[grant_port];
            end else begin
              cnt_reg  <= RD_LOAD;
              oe_n_reg <= 1'b0;
              doe_reg  <= 1'b0;
            end
          end
        end
        ACCESS: begin
          if (cnt_reg == '0) begin
            // Strobes rise together. CE, address and write data stay
            // valid for one more cycle of hold time.
            state_reg <= ACK;
            oe_n_reg  <= 1'b1;
            we_n_reg  <= 1'b1;
          end else begin
            cnt_reg <= cnt_reg - CNT_ONE;
          end
        end
        ACK: begin
          // Always go back through IDLE, so there is a dead cycle between grants
          state_reg <= IDLE;
          ce_n_reg  <= 1'b1;
          doe_reg   <= 1'b0;
          busy_reg  <= 1'b0;
        end
        default: begin
          state_reg <= IDLE;
          ce_n_reg  <= 1'b1;
          oe_n_reg  <= 1'b1;
          we_n_reg  <= 1'b1;
          doe_reg   <= 1'b0;
          busy_reg  <= 1'b0;
        end
      endcase
    end
  end

  for (genvar gi = 0; gi < 2; gi++) begin : g_port
    // Per-port response: a one-cycle Ack, plus read data captured only for the grantee
    always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
        ack_reg[gi]   <= 1'b0;
        rdata_reg[gi] <= '0;
      end else begin
        ack_reg[gi] <= access_done && (owner_reg == 1'(gi));
        if (access_done && !we_reg && (owner_reg == 1'(gi))) begin
          rdata_reg[gi] <= bus.SRAM_Din;
        end
      end
    end
  end

  assign bus.CPU_Ack   = ack_reg[0];
  assign bus.DMA_Ack   = ack_reg[1];
  assign bus.CPU_Rdata = rdata_reg[0];
  assign bus.DMA_Rdata = rdata_reg[1];

  assign bus.SRAM_ADDR = addr_reg;
  assign bus.SRAM_Dout = dout_reg;
  assign bus.SRAM_Doe  = doe_reg;
  assign bus.SRAM_CE_N = ce_n_reg;
  assign bus.SRAM_OE_N = oe_n_reg;
  assign bus.SRAM_WE_N = we_n_reg;
  assign bus.Busy      = busy_reg;
  assign bus.Owner     = owner_reg;

endmodule

// File: tb/tb_sram_arbiter.sv
// Directed bench for sram_arbiter with a small behavioural SRAM model.
// It covers reset, single reads and writes, round-robin contention,
// address change after grant, Req dropped mid-access, and reset mid-write.
module tb_sram_arbiter;

  localparam int AW = 20;
  localparam int DW = 16;
  localparam int RW = 2;
  localparam int WW = 2;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  sram_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  sram_arbiter #(
    .ADDR_W (AW),
    .DATA_W (DW),
    .RD_WAIT(RW),
    .WR_WAIT(WW)
  ) dut (
    .Clk    (clk),
    .Reset_n(reset_n),
    .bus    (bus)
  );

  // SRAM model: 256 words indexed by the low address byte, preloaded once
  logic [DW-1:0] mem [256];
  bit preloaded;
  always @(posedge clk) begin
    if (!preloaded) begin
      mem[8'h23] <= 16'hBEEF;
      mem[8'hCD] <= 16'h0000;
      preloaded  <= 1'b1;
    end else if (!bus.SRAM_CE_N && !bus.SRAM_WE_N && bus.SRAM_Doe) begin
      mem[bus.SRAM_ADDR[7:0]] <= bus.SRAM_Dout;
    end
  end
  assign bus.SRAM_Din = (!bus.SRAM_CE_N && !bus.SRAM_OE_N) ? mem[bus.SRAM_ADDR[7:0]] : '0;

  int checks = 0;
  int errors = 0;

  task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive_port(input bit port, input bit req, input bit we,
                            input logic [AW-1:0] addr, input logic [DW-1:0] wdata);
    if (port) begin
      bus.DMA_Req = req; bus.DMA_WE = we; bus.DMA_Addr = addr; bus.DMA_Wdata = wdata;
    end else begin
      bus.CPU_Req = req; bus.CPU_WE = we; bus.CPU_Addr = addr; bus.CPU_Wdata = wdata;
    end
  endtask

  task automatic apply_reset();
    drive_port(1'b0, 1'b0, 1'b0, '0, '0);
    drive_port(1'b1, 1'b0, 1'b0, '0, '0);
    @(negedge clk);
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
  endtask

  // Results of the most recent run_access
  int r_lat, r_rd, r_wr, r_own, r_other, r_addr_err;
  logic r_busy_first, r_busy_end, r_ack_doe;
  logic [DW-1:0] r_ack_dout;

  // One access on one port, observed for 8 cycles after the grant edge
  task automatic run_access(input bit port, input bit we, input logic [AW-1:0] addr,
                            input logic [DW-1:0] wdata, input bit drop_early, input bit change_addr);
    logic own_ack, other_ack;
    r_lat = -1; r_rd = 0; r_wr = 0; r_own = 0; r_other = 0; r_addr_err = 0;
    r_busy_first = 1'b0; r_busy_end = 1'b1; r_ack_doe = 1'b0; r_ack_dout = '0;
    @(posedge clk); #1;
    drive_port(port, 1'b1, we, addr, wdata);
    @(posedge clk); #1;
    if (change_addr) drive_port(port, 1'b1, we, ~addr, ~wdata);
    if (drop_early)  drive_port(port, 1'b0, we, addr, wdata);
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      own_ack   = port ? bus.DMA_Ack : bus.CPU_Ack;
      other_ack = port ? bus.CPU_Ack : bus.DMA_Ack;
      if (k == 1) r_busy_first = bus.Busy;
      if (!bus.SRAM_OE_N) r_rd++;
      if (!bus.SRAM_WE_N) r_wr++;
      if (!bus.SRAM_CE_N && bus.SRAM_ADDR !== addr) r_addr_err++;
      if (own_ack) begin
        r_own++;
        if (r_lat < 0) r_lat = k;
        r_ack_doe  = bus.SRAM_Doe;
        r_ack_dout = bus.SRAM_Dout;
        if (port) bus.DMA_Req = 1'b0; else bus.CPU_Req = 1'b0;
      end
      if (other_ack) r_other++;
    end
    r_busy_end = bus.Busy;
    $display("txn port=%0d we=%0d addr=%05h wdata=%04h lat=%0d acks=%0d cpu_rdata=%04h dma_rdata=%04h",
             port, we, addr, wdata, r_lat, r_own, bus.CPU_Rdata, bus.DMA_Rdata);
  endtask

  // Expected shape of a complete, single access
  task automatic check_shape(input string name, input bit we, input logic [DW-1:0] wdata);
    check_value({name, "_ack_lat"}, r_lat, we ? WW + 1 : RW + 1);
    check_value({name, "_ack_count"}, r_own, 1);
    check_value({name, "_other_ack"}, r_other, 0);
    check_value({name, "_oe_cycles"}, r_rd, we ? 0 : RW);
    check_value({name, "_we_cycles"}, r_wr, we ? WW : 0);
    check_value({name, "_addr_held"}, r_addr_err, 0);
    check_value({name, "_busy_rise"}, r_busy_first, 1'b1);
    check_value({name, "_busy_fall"}, r_busy_end, 1'b0);
    if (we) begin
      check_value({name, "_ack_doe"}, r_ack_doe, 1'b1);
      check_value({name, "_ack_dout"}, r_ack_dout, wdata);
    end
  endtask

  int n_ack, last_k, both_cnt;
  int order [4];
  int gaps [3];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    drive_port(1'b0, 1'b0, 1'b0, '0, '0);
    drive_port(1'b1, 1'b0, 1'b0, '0, '0);
    reset_n = 1'b0;
    repeat (3) @(negedge clk);

    // Reset state
    check_value("rst_ce_n", bus.SRAM_CE_N, 1'b1);
    check_value("rst_oe_n", bus.SRAM_OE_N, 1'b1);
    check_value("rst_we_n", bus.SRAM_WE_N, 1'b1);
    check_value("rst_doe", bus.SRAM_Doe, 1'b0);
    check_value("rst_addr", bus.SRAM_ADDR, 20'h0);
    check_value("rst_dout", bus.SRAM_Dout, 16'h0);
    check_value("rst_busy", bus.Busy, 1'b0);
    check_value("rst_owner", bus.Owner, 1'b1);
    check_value("rst_acks", {bus.CPU_Ack, bus.DMA_Ack}, 2'b00);
    check_value("rst_cpu_rdata", bus.CPU_Rdata, 16'h0);
    check_value("rst_dma_rdata", bus.DMA_Rdata, 16'h0);
    reset_n = 1'b1;

    // CPU read of the preloaded word
    run_access(1'b0, 1'b0, 20'h00123, 16'h0, 1'b0, 1'b0);
    check_shape("cpu_rd", 1'b0, 16'h0);
    check_value("cpu_rd_data", bus.CPU_Rdata, 16'hBEEF);
    check_value("cpu_rd_owner", bus.Owner, 1'b0);

    // DMA write; Rdata registers must not move
    run_access(1'b1, 1'b1, 20'h0ABCD, 16'h1234, 1'b0, 1'b0);
    check_shape("dma_wr", 1'b1, 16'h1234);
    check_value("dma_wr_dma_rdata", bus.DMA_Rdata, 16'h0);
    check_value("dma_wr_cpu_rdata", bus.CPU_Rdata, 16'hBEEF);
    check_value("dma_wr_owner", bus.Owner, 1'b1);

    // Read back the DMA write through the CPU port
    run_access(1'b0, 1'b0, 20'h0ABCD, 16'h0, 1'b0, 1'b0);
    check_shape("cpu_rb", 1'b0, 16'h0);
    check_value("cpu_rb_data", bus.CPU_Rdata, 16'h1234);

    // Address and data change right after the grant
    run_access(1'b0, 1'b0, 20'h00123, 16'h0, 1'b0, 1'b1);
    check_shape("addr_chg", 1'b0, 16'h0);
    check_value("addr_chg_data", bus.CPU_Rdata, 16'hBEEF);

    // Req dropped in the first ACCESS cycle
    run_access(1'b0, 1'b0, 20'h0ABCD, 16'h0, 1'b1, 1'b0);
    check_shape("req_drop", 1'b0, 16'h0);
    check_value("req_drop_data", bus.CPU_Rdata, 16'h1234);

    // DMA read leaves the CPU data alone
    run_access(1'b1, 1'b0, 20'h00123, 16'h0, 1'b0, 1'b0);
    check_shape("dma_rd", 1'b0, 16'h0);
    check_value("dma_rd_data", bus.DMA_Rdata, 16'hBEEF);
    check_value("dma_rd_cpu_rdata", bus.CPU_Rdata, 16'h1234);

    // Contention from reset: expect CPU, DMA, CPU, DMA with acks 4 cycles apart
    apply_reset();
    @(posedge clk); #1;
    drive_port(1'b0, 1'b1, 1'b0, 20'h00123, 16'h0);
    drive_port(1'b1, 1'b1, 1'b0, 20'h0ABCD, 16'h0);
    n_ack = 0; last_k = 0; both_cnt = 0;
    for (int i = 0; i < 4; i++) order[i] = 2;
    for (int i = 0; i < 3; i++) gaps[i] = 0;
    for (int k = 1; k <= 40 && n_ack < 4; k++) begin
      @(negedge clk);
      if (bus.CPU_Ack && bus.DMA_Ack) both_cnt++;
      if (bus.CPU_Ack || bus.DMA_Ack) begin
        order[n_ack] = bus.DMA_Ack ? 1 : 0;
        if (n_ack > 0) gaps[n_ack-1] = k - last_k;
        last_k = k;
        $display("txn contention ack #%0d port=%0d cycle=%0d", n_ack, order[n_ack], k);
        n_ack++;
      end
    end
    drive_port(1'b0, 1'b0, 1'b0, 20'h0, 16'h0);
    drive_port(1'b1, 1'b0, 1'b0, 20'h0, 16'h0);
    check_value("cont_ack_total", n_ack, 4);
    check_value("cont_both_ack", both_cnt, 0);
    for (int i = 0; i < 4; i++) check_value($sformatf("cont_order%0d", i), order[i], i % 2);
    for (int i = 0; i < 3; i++) check_value($sformatf("cont_gap%0d", i), gaps[i], RW + 2);
    repeat (3) @(negedge clk);
    check_value("cont_cpu_rdata", bus.CPU_Rdata, 16'hBEEF);
    check_value("cont_dma_rdata", bus.DMA_Rdata, 16'h1234);
    check_value("cont_idle", bus.Busy, 1'b0);

    // Reset asserted in the middle of a CPU write
    @(posedge clk); #1;
    drive_port(1'b0, 1'b1, 1'b1, 20'h00055, 16'h5555);
    @(posedge clk);
    @(negedge clk);
    check_value("midrst_pre_we_n", bus.SRAM_WE_N, 1'b0);
    check_value("midrst_pre_owner", bus.Owner, 1'b0);
    #1 reset_n = 1'b0;
    #1;
    check_value("midrst_we_n", bus.SRAM_WE_N, 1'b1);
    check_value("midrst_ce_n", bus.SRAM_CE_N, 1'b1);
    check_value("midrst_doe", bus.SRAM_Doe, 1'b0);
    check_value("midrst_busy", bus.Busy, 1'b0);
    check_value("midrst_owner", bus.Owner, 1'b1);
    check_value("midrst_cpu_rdata", bus.CPU_Rdata, 16'h0);
    drive_port(1'b0, 1'b0, 1'b0, 20'h0, 16'h0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    n_ack = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (bus.CPU_Ack || bus.DMA_Ack) n_ack++;
    end
    $display("txn reset mid-write: acks after release=%0d owner=%0d", n_ack, bus.Owner);
    check_value("midrst_no_ack", n_ack, 0);
    check_value("midrst_owner_after", bus.Owner, 1'b1);
    check_value("midrst_idle_after", bus.Busy, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sram_arbiter.md
# sram_arbiter

- Two-port SRAM arbiter and access sequencer between the LC-3 CPU memory path and a secondary bus master (program loader / debug port).
- Grants one requester at a time using round-robin.
- Drives the single-ported SRAM control strobes with programmable read/write wait states, and returns read data with a one-cycle Ack pulse.
- Replaces direct Mem_OE/Mem_WE wiring from the control unit, so the control unit's memory states wait on Ack instead of fixed cycle counts.

## Interface

Parameters:
- ADDR_W, 20, SRAM address width
- DATA_W, 16, SRAM data width
- RD_WAIT, 2, cycles OE_N is held low per read (≥1)
- WR_WAIT, 2, cycles WE_N is held low per write (≥1)

Ports:
- Clk  in  1  system clock, all state updates on rising edge
- Reset_n  in  1  one clock; reset is asynchronous and active-low
- CPU_Req  in  1  CPU access request, held until CPU_Ack
- CPU_WE  in  1  1 = write, 0 = read
- CPU_Addr  in  ADDR_W  CPU address
- CPU_Wdata  in  DATA_W  CPU write data
- CPU_Rdata  out  DATA_W  CPU read data, registered
- CPU_Ack  out  1  one-cycle completion pulse
- DMA_Req, DMA_WE, DMA_Addr, DMA_Wdata, DMA_Rdata, DMA_Ack  same widths and meaning as the CPU_* ports, for the secondary master
- SRAM_ADDR  out  ADDR_W  SRAM address
- SRAM_Dout  out  DATA_W  data toward SRAM
- SRAM_Doe  out  1  tristate enable for SRAM_Dout
- SRAM_Din  in  DATA_W  data from SRAM
- SRAM_CE_N, SRAM_OE_N, SRAM_WE_N  out  1 each  active-low SRAM strobes
- Busy  out  1  high in any state other than IDLE
- Owner  out  1  current/last grantee: 0 = CPU, 1 = DMA

## Operation

States: IDLE, ACCESS, ACK.

IDLE:
- If no request is pending, remain in IDLE.
- If exactly one request is pending, grant it.
- If both requests are pending, grant the port that is not Owner (round-robin). Owner resets to 1, so the CPU wins the first tie.
- On grant: latch WE, Addr and Wdata of the grantee into internal registers, set Owner, load the wait counter with RD_WAIT-1 or WR_WAIT-1, and go to ACCESS.

ACCESS:
- SRAM_CE_N = 0 and SRAM_ADDR = latched address.
- Read: SRAM_OE_N = 0 and SRAM_Doe = 0.
- Write: SRAM_WE_N = 0, SRAM_Doe = 1 and SRAM_Dout = latched data.
- Counter decrements each cycle. At counter = 0:
  - a read captures SRAM_Din into the grantee's Rdata register;
  - go to ACK.

ACK:
- Grantee's Ack = 1 for exactly this one cycle.
- SRAM_CE_N = 0, SRAM_OE_N = 1, SRAM_WE_N = 1.
- Address held, and SRAM_Doe held for writes (one-cycle hold time).
- Next state is always IDLE. There is no back-to-back grant from ACK; a dead IDLE cycle separates all accesses.

Handshake and boundary cases:
- Requesters may change Addr/Wdata any time after the grant edge; the arbiter uses latched copies only.
- A requester must drop Req in the cycle after Ack. If Req is still high in IDLE, it is a new request.
- Req dropped mid-access: the access still completes and Ack is still pulsed.
- Rdata registers hold their value until the next read completion for the same port. Writes never modify Rdata.
- The non-granted port's Ack stays 0 throughout.

Reset values (asynchronous, immediate on Reset_n = 0, including mid-access):
- State = IDLE, Owner = 1, counter = 0.
- CPU_Ack = DMA_Ack = 0, CPU_Rdata = DMA_Rdata = 0.
- SRAM_CE_N = SRAM_OE_N = SRAM_WE_N = 1, SRAM_Doe = 0, SRAM_ADDR = 0, SRAM_Dout = 0, Busy = 0.
- An interrupted access produces no Ack after reset releases.

Counter width is $clog2(max(RD_WAIT,WR_WAIT)) + 1 bits.

## Timing

- All SRAM outputs are registered; no combinational path runs from Req to the SRAM pins.
- Read: Req sampled high in IDLE at edge t. OE_N is low for cycles t+1 … t+RD_WAIT. Ack is high in cycle t+RD_WAIT+1, with Rdata valid in the same cycle.
- Write: same shape with WR_WAIT. WE_N is low for WR_WAIT cycles, and data is driven through the ACK cycle.
- Occupancy per access is wait + 2 cycles. With both ports requesting continuously, each port gets one access every 2·(wait+2) cycles.
- Busy rises one cycle after the sampled request and falls on the edge leaving ACK.

## Test plan

- **Reset:** drive Reset_n low mid-ACCESS of a write → WE_N, CE_N = 1 and Doe = 0 within the same cycle; after release, no Ack and Owner = 1.
- **CPU read:** RD_WAIT = 2, SRAM model returns 16'hBEEF at 20'h00123 → OE_N low for exactly 2 cycles, CPU_Ack pulses once 3 cycles after grant, CPU_Rdata = 16'hBEEF, DMA_Ack = 0.
- **DMA write:** DMA writes 16'h1234 to 20'h0ABCD with WR_WAIT = 2 → WE_N low for 2 cycles, SRAM_Dout = 16'h1234 with Doe = 1 through ACK, readback through the CPU port returns 16'h1234.
- **Contention:** CPU_Req and DMA_Req both held for 4 accesses → grant order CPU, DMA, CPU, DMA, with one IDLE cycle between accesses.
- **Address change after grant:** CPU_Addr changes the cycle after grant → SRAM_ADDR keeps the originally latched value through ACK.
- **Req drop mid-access:** CPU_Req deasserted in the first ACCESS cycle → access completes, CPU_Ack still pulses, and no second access starts.
